// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  // Default operand width in bits (legal range 2..32).
  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_e;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout set when a borrow is needed.
module full_subtractor_bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  // Difference and borrow-out for a single bit position.
  always_comb begin
    Diff = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A-B LSB-first over WIDTH cycles,
// then publishes Diff/Borrow with a one-cycle done pulse.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  // One extra bit so the counter can represent WIDTH itself.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bflop_q, bflop_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_diff;
  logic             bit_bout;
  logic             last_bit;

  // Per-bit arithmetic on the current operand LSBs.
  full_subtractor_bit u_bit (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (bflop_q),
    .Diff (bit_diff),
    .Bout (bit_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: operand capture, serial shift, result publication.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bflop_d  = bflop_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          cnt_d   = '0;
          bflop_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        res_d   = {bit_diff, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        bflop_d = bit_bout;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        diff_d   = res_q;
        borrow_d = bflop_q;
        done_d   = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bflop_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bflop_q  <= bflop_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;
  localparam int LAT = 9;      // edges from start sample to done visible
  localparam int PERIOD = 10;  // cycles per result with start held high

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Borrow;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Diff   (Diff),
    .Borrow (Borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned m;
    m = (int'(a) - int'(b) + 256) % 256;
    return W'(m);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return (int'(a) < int'(b));
  endfunction

  // Issue one operation from an idle cycle (#1 after an edge) and observe it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit jam,
                       output logic [W-1:0] d, output logic bo,
                       output int lat, output int bcyc, output int ndone);
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcyc = 0; ndone = 0; d = 'x; bo = 1'bx;
    if (busy === 1'b1) bcyc++;
    for (int n = 1; n <= 40; n++) begin
      if (jam && lat == 0) begin
        start = 1'($urandom_range(0, 1));
        A = W'($urandom);
        B = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy === 1'b1) bcyc++;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = n; d = Diff; bo = Borrow;
        end
      end
      if (lat != 0 && n >= lat + 12) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (Diff !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h exp=00", Diff); end
    total++; if (Borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", Borrow); end
    repeat (3) @(posedge clk);
    // start already high when reset releases: first edge must accept it
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; A = 8'd200; B = 8'd50;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin n = i; break; end
    end
    total++; if (n != LAT) begin bad++; $display("FAIL first_start_latency got=%0d exp=%0d", n, LAT); end
    total++; if (Diff !== 8'd150) begin bad++; $display("FAIL first_start_diff got=%0d exp=150", Diff); end
    total++; if (Borrow !== 1'b0) begin bad++; $display("FAIL first_start_borrow got=%b exp=0", Borrow); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [0:3];
    logic [W-1:0] vb [0:3];
    logic [W-1:0] a, b, d;
    logic bo;
    int lat, bcyc, nd;
    va[0] = 8'd100; vb[0] = 8'd37;
    va[1] = 8'd5;   vb[1] = 8'd10;
    va[2] = 8'h00;  vb[2] = 8'h01;
    va[3] = 8'hFF;  vb[3] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin a = va[i]; b = vb[i]; end
      else begin a = W'($urandom); b = W'($urandom); end
      do_op(a, b, 1'b0, d, bo, lat, bcyc, nd);
      total++; if (d !== ref_diff(a, b)) begin bad++; $display("FAIL directed_diff a=%0d b=%0d got=%h exp=%h", a, b, d, ref_diff(a, b)); end
      total++; if (bo !== ref_borrow(a, b)) begin bad++; $display("FAIL directed_borrow a=%0d b=%0d got=%b exp=%b", a, b, bo, ref_borrow(a, b)); end
      total++; if (lat != LAT) begin bad++; $display("FAIL directed_latency got=%0d exp=%0d", lat, LAT); end
      total++; if (bcyc != LAT) begin bad++; $display("FAIL directed_busy_cycles got=%0d exp=%0d", bcyc, LAT); end
      total++; if (nd != 1) begin bad++; $display("FAIL directed_done_count got=%0d exp=1", nd); end
    end
  endtask

  task automatic test_jam();
    logic [W-1:0] a, b, d;
    logic bo;
    int lat, bcyc, nd;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom);
      do_op(a, b, 1'b1, d, bo, lat, bcyc, nd);
      total++; if (d !== ref_diff(a, b)) begin bad++; $display("FAIL jam_diff a=%0d b=%0d got=%h exp=%h", a, b, d, ref_diff(a, b)); end
      total++; if (bo !== ref_borrow(a, b)) begin bad++; $display("FAIL jam_borrow got=%b exp=%b", bo, ref_borrow(a, b)); end
      total++; if (nd != 1) begin bad++; $display("FAIL jam_done_count got=%0d exp=1", nd); end
      total++; if (lat != LAT) begin bad++; $display("FAIL jam_latency got=%0d exp=%0d", lat, LAT); end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] d;
    logic bo;
    int lat, bcyc, nd;
    do_op(8'd77, 8'd200, 1'b0, d, bo, lat, bcyc, nd);
    for (int i = 0; i < 6; i++) begin
      A = W'($urandom); B = W'($urandom);
      @(posedge clk); #1;
      total++; if (Diff !== ref_diff(8'd77, 8'd200)) begin bad++; $display("FAIL hold_diff got=%h exp=%h", Diff, ref_diff(8'd77, 8'd200)); end
      total++; if (Borrow !== 1'b1) begin bad++; $display("FAIL hold_borrow got=%b exp=1", Borrow); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_done got=%b exp=0", done); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b, d;
    logic bo;
    int lat, bcyc, nd;
    do_op(8'd9, 8'd4, 1'b0, d, bo, lat, bcyc, nd);
    total++; if (d !== 8'd5) begin bad++; $display("FAIL premid_diff got=%0d exp=5", d); end
    start = 1'b1; A = 8'd250; B = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=%b exp=0", done); end
    total++; if (Diff !== 8'h00) begin bad++; $display("FAIL mid_reset_diff got=%h exp=00", Diff); end
    total++; if (Borrow !== 1'b0) begin bad++; $display("FAIL mid_reset_borrow got=%b exp=0", Borrow); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL mid_reset_no_done got=%0d exp=0", nd); end
    a = W'($urandom); b = W'($urandom);
    do_op(a, b, 1'b0, d, bo, lat, bcyc, nd);
    total++; if (d !== ref_diff(a, b)) begin bad++; $display("FAIL post_reset_diff got=%h exp=%h", d, ref_diff(a, b)); end
    total++; if (bo !== ref_borrow(a, b)) begin bad++; $display("FAIL post_reset_borrow got=%b exp=%b", bo, ref_borrow(a, b)); end
    total++; if (lat != LAT) begin bad++; $display("FAIL post_reset_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 1000;
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    logic [W-1:0] a, b;
    int pushed, ndone, last_cyc;
    pushed = 0; ndone = 0; last_cyc = -1;
    a = W'($urandom); b = W'($urandom);
    start = 1'b1; A = a; B = b;
    qa.push_back(a); qb.push_back(b); pushed++;
    for (int cyc = 0; cyc < NOPS * PERIOD + 50; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (qa.size() > 0) begin
          a = qa.pop_front(); b = qb.pop_front();
          total++; if (Diff !== ref_diff(a, b)) begin bad++; $display("FAIL b2b_diff op=%0d a=%0d b=%0d got=%h exp=%h", ndone, a, b, Diff, ref_diff(a, b)); end
          total++; if (Borrow !== ref_borrow(a, b)) begin bad++; $display("FAIL b2b_borrow op=%0d got=%b exp=%b", ndone, Borrow, ref_borrow(a, b)); end
        end
        if (last_cyc >= 0) begin
          total++; if (cyc - last_cyc != PERIOD) begin bad++; $display("FAIL b2b_period op=%0d got=%0d exp=%0d", ndone, cyc - last_cyc, PERIOD); end
        end
        last_cyc = cyc;
        ndone++;
        if (pushed < NOPS) begin
          a = W'($urandom); b = W'($urandom);
          A = a; B = b;
          qa.push_back(a); qb.push_back(b); pushed++;
        end else begin
          start = 1'b0;
        end
        if (ndone == NOPS) break;
      end else begin
        A = W'($urandom); B = W'($urandom);
      end
    end
    start = 1'b0;
    total++; if (ndone != NOPS) begin bad++; $display("FAIL b2b_result_count got=%0d exp=%0d", ndone, NOPS); end
    repeat (12) @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_jam();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled on a rising clk edge.
REQ-005 The block SHALL have port A, input, WIDTH bits, the minuend, sampled with start.
REQ-006 The block SHALL have port B, input, WIDTH bits, the subtrahend, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid new result.
REQ-009 The block SHALL have port Diff, output, WIDTH bits, the result A-B modulo 2^WIDTH.
REQ-010 The block SHALL have port Borrow, output, 1 bit, set when A < B as unsigned values.

Function
REQ-011 The block SHALL implement the three-state FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-012 In IDLE, start=1 SHALL latch A and B into shift registers, clear the borrow flop and the bit counter, and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL process the operand LSBs a, b with borrow-in bin: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
REQ-014 In each SHIFT cycle, d SHALL enter the result register at its MSB, the result register SHALL shift right, both operands SHALL shift right, bout SHALL load the borrow flop, and the counter SHALL increment.
REQ-015 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-016 On entry to DONE, Diff SHALL load the result register, Borrow SHALL load the final bout, and done SHALL be high for that one cycle only.
REQ-017 From DONE, the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH+1.
REQ-019 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-020 start SHALL be ignored while busy=1; the in-flight operation and its operands SHALL be unaffected.
REQ-021 Diff and Borrow SHALL hold their values until the next DONE; changes on A and B after the start sample SHALL have no effect.
REQ-022 Back-to-back: start sampled in the IDLE cycle immediately following DONE SHALL be accepted.
REQ-023 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation (0 - 1 = all-ones, Borrow=1).
REQ-024 The counter SHALL be $clog2(WIDTH)+1 bits wide so that it does not overflow at WIDTH.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE, and busy=0, done=0, Diff=0, Borrow=0, with the borrow flop, counter and shift registers all zero.
REQ-026 Reset asserted mid-operation SHALL abort the operation immediately, and no done pulse SHALL follow.
REQ-027 Deassertion of rst_n SHALL be the only way to leave reset; the first start SHALL be honoured on the first rising edge with rst_n=1.

Structure
REQ-028 The state enum (IDLE, SHIFT, DONE) and the WIDTH default SHALL reside in the shared package serial_sub_pkg.
REQ-029 The per-bit logic of REQ-013 SHALL be a combinational sub-module full_subtractor_bit (ports A, B, Bin, Diff, Bout), instantiated once.
REQ-030 All sequential logic SHALL use a single clk domain with asynchronous rst_n; there SHALL be no latches.

Verification (WIDTH=8)
REQ-031 A=100, B=37, start for 1 cycle -> done pulse 9 edges after the start edge; Diff=63, Borrow=0; busy high for 9 cycles.
REQ-032 A=5, B=10 -> Diff=0xFB, Borrow=1; A=0x00, B=0x01 -> Diff=0xFF, Borrow=1; A=0xFF, B=0xFF -> Diff=0x00, Borrow=0.
REQ-033 Random start pulses and A/B changes while busy -> the result matches the first-sampled operands and exactly one done pulse occurs.
REQ-034 rst_n pulsed low during SHIFT cycle 4 -> all outputs 0 immediately, no done pulse, and a new operation then completes correctly.
REQ-035 Back-to-back operations (start held high) -> one result every 10 cycles; the scoreboard matches (A-B) mod 256 and A<B for 1000 random pairs.
